// File: rtl/spot_box_overlay_pkg.sv
// Shared video-overlay definitions: default geometry, colour constants and
// the coordinate-set record passed between spot detector and overlay.
package spot_box_overlay_pkg;

    localparam logic [10:0] DEF_IMG_HDISP        = 11'd1280;
    localparam logic [10:0] DEF_IMG_VDISP        = 11'd720;
    localparam logic [9:0]  DEF_BOX_WIDTH        = 10'd100;
    localparam logic [9:0]  DEF_BOX_HEIGHT       = 10'd100;
    localparam logic [3:0]  DEF_BORDER_THICKNESS = 4'd2;
    localparam logic [3:0]  DEF_MISS_LIMIT       = 4'd4;

    localparam logic [23:0] RGB_RED   = 24'hFF0000;
    localparam logic [23:0] RGB_GREEN = 24'h00FF00;
    localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
    localparam logic [23:0] RGB_BLACK = 24'h000000;

    typedef struct packed {
        logic        valid;
        logic [10:0] x1;
        logic [15:0] y1;
        logic [10:0] x2;
        logic [15:0] y2;
    } coord_set_t;

    // Box 1 outranks box 2; outside any border the binary pixel shows through.
    function automatic logic [23:0] overlay_rgb(input logic clken, input logic hit1,
                                                input logic hit2, input logic pix);
        logic [23:0] rgb;
        if (!clken)
            rgb = RGB_BLACK;
        else if (hit1)
            rgb = RGB_RED;
        else if (hit2)
            rgb = RGB_GREEN;
        else if (pix)
            rgb = RGB_WHITE;
        else
            rgb = RGB_BLACK;
        return rgb;
    endfunction

endpackage

// File: rtl/spot_box_overlay_border.sv
// Clamped box bounds around one spot centre, latched once per frame, and the
// border-pixel test against the current pixel position.
module box_border_hit
    import spot_box_overlay_pkg::*;
#(
    parameter logic [10:0] IMG_HDISP = DEF_IMG_HDISP,
    parameter logic [10:0] IMG_VDISP = DEF_IMG_VDISP,
    parameter logic [9:0]  HALF_W    = DEF_BOX_WIDTH >> 1,
    parameter logic [9:0]  HALF_H    = DEF_BOX_HEIGHT >> 1,
    parameter logic [3:0]  BORDER    = DEF_BORDER_THICKNESS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_en,
    input  logic [10:0] i_cx,
    input  logic [15:0] i_cy,
    input  logic [10:0] i_px,
    input  logic [10:0] i_py,
    output logic        o_hit
);

    localparam logic [16:0] W_HDISP = {6'd0, IMG_HDISP};
    localparam logic [16:0] W_VDISP = {6'd0, IMG_VDISP};
    localparam logic [16:0] W_HW    = {7'd0, HALF_W};
    localparam logic [16:0] W_HH    = {7'd0, HALF_H};
    localparam logic [16:0] W_T     = {13'd0, BORDER};

    logic [16:0] w_cx, w_cy, w_xsum, w_ysum;
    logic [16:0] w_xmin_nx, w_xmax_nx, w_ymin_nx, w_ymax_nx;
    logic [16:0] r_xmin, r_xmax, r_ymin, r_ymax;
    logic [16:0] w_px, w_py;
    logic        w_inside, w_edge;

    assign w_cx   = {6'd0, i_cx};
    assign w_cy   = {1'b0, i_cy};
    assign w_xsum = w_cx + W_HW;
    assign w_ysum = w_cy + W_HH;

    always_comb begin
        w_xmin_nx = (w_cx > W_HW)      ? w_cx - W_HW : '0;
        w_xmax_nx = (w_xsum < W_HDISP) ? w_xsum      : W_HDISP - 17'd1;
        w_ymin_nx = (w_cy > W_HH)      ? w_cy - W_HH : '0;
        w_ymax_nx = (w_ysum < W_VDISP) ? w_ysum      : W_VDISP - 17'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xmin <= '0;
            r_xmax <= '0;
            r_ymin <= '0;
            r_ymax <= '0;
        end else if (i_load) begin
            r_xmin <= w_xmin_nx;
            r_xmax <= w_xmax_nx;
            r_ymin <= w_ymin_nx;
            r_ymax <= w_ymax_nx;
        end
    end

    assign w_px = {6'd0, i_px};
    assign w_py = {6'd0, i_py};

    // "p > max - T" is written as "p + T > max" so a small max cannot underflow.
    assign w_inside = (w_px >= r_xmin) && (w_px <= r_xmax) &&
                      (w_py >= r_ymin) && (w_py <= r_ymax);
    assign w_edge   = (w_px < r_xmin + W_T) || (w_px + W_T > r_xmax) ||
                      (w_py < r_ymin + W_T) || (w_py + W_T > r_ymax);
    assign o_hit    = i_en && w_inside && w_edge;

endmodule

// File: rtl/spot_box_overlay.sv
// Draws red/green border boxes around two detected spots on a binary video
// stream, with a two-cycle pipeline and frame-synchronous coordinate update.
module spot_box_overlay
    import spot_box_overlay_pkg::*;
#(
    parameter logic [10:0] IMG_HDISP        = DEF_IMG_HDISP,
    parameter logic [10:0] IMG_VDISP        = DEF_IMG_VDISP,
    parameter logic [9:0]  BOX_WIDTH        = DEF_BOX_WIDTH,
    parameter logic [9:0]  BOX_HEIGHT       = DEF_BOX_HEIGHT,
    parameter logic [3:0]  BORDER_THICKNESS = DEF_BORDER_THICKNESS,
    parameter logic [3:0]  MISS_LIMIT       = DEF_MISS_LIMIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic        per_img_Bit,
    input  logic [10:0] x_max_1,
    input  logic [15:0] y_max_1,
    input  logic [10:0] x_max_2,
    input  logic [15:0] y_max_2,
    input  logic        coords_valid,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic [23:0] post_img_rgb,
    output logic [1:0]  boxes_active
);

    localparam logic [9:0] HALF_W = BOX_WIDTH >> 1;
    localparam logic [9:0] HALF_H = BOX_HEIGHT >> 1;

    logic        r_vs_d1, r_hr_d1, r_ck_d1, r_bit_d1;
    logic [1:0]  r_hit;
    logic [10:0] r_x_cnt, r_y_cnt;
    coord_set_t  r_pend, r_act, w_act_nx;
    logic [3:0]  r_miss, w_miss_nx;
    logic [1:0]  w_en_nx;
    logic        w_frame_start;
    logic        w_hit1, w_hit2;

    assign w_frame_start = per_frame_vsync & ~r_vs_d1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d1          <= 1'b0;
            r_hr_d1          <= 1'b0;
            r_ck_d1          <= 1'b0;
            r_bit_d1         <= 1'b0;
            r_hit            <= '0;
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_rgb     <= '0;
        end else begin
            r_vs_d1          <= per_frame_vsync;
            r_hr_d1          <= per_frame_href;
            r_ck_d1          <= per_frame_clken;
            r_bit_d1         <= per_img_Bit;
            r_hit            <= {w_hit2, w_hit1};
            post_frame_vsync <= r_vs_d1;
            post_frame_href  <= r_hr_d1;
            post_frame_clken <= r_ck_d1;
            post_img_rgb     <= overlay_rgb(r_ck_d1, r_hit[0], r_hit[1], r_bit_d1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_cnt <= '0;
            r_y_cnt <= '0;
        end else if (w_frame_start) begin
            r_x_cnt <= '0;
            r_y_cnt <= '0;
        end else if (per_frame_clken) begin
            if (r_x_cnt == IMG_HDISP - 11'd1) begin
                r_x_cnt <= '0;
                r_y_cnt <= r_y_cnt + 11'd1;
            end else begin
                r_x_cnt <= r_x_cnt + 11'd1;
            end
        end
    end

    // State the frame will run with; also feeds the per-frame bound latch.
    always_comb begin
        w_act_nx  = r_act;
        w_miss_nx = r_miss;
        if (r_pend.valid) begin
            w_act_nx  = r_pend;
            w_miss_nx = '0;
        end else if (r_miss < MISS_LIMIT) begin
            w_miss_nx = r_miss + 4'd1;
        end
        w_en_nx[0] = w_act_nx.valid && (w_miss_nx < MISS_LIMIT) &&
                     (w_act_nx.y1 < {5'd0, IMG_VDISP});
        w_en_nx[1] = w_act_nx.valid && (w_miss_nx < MISS_LIMIT) &&
                     (w_act_nx.y2 < {5'd0, IMG_VDISP});
    end

    // A strobe on the frame-start cycle wins over the clear, so it lands in
    // pending and is only consumed at the following frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else if (coords_valid) begin
            r_pend <= {1'b1, x_max_1, y_max_1, x_max_2, y_max_2};
        end else if (w_frame_start) begin
            r_pend.valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act        <= '0;
            r_miss       <= '0;
            boxes_active <= '0;
        end else if (w_frame_start) begin
            r_act        <= w_act_nx;
            r_miss       <= w_miss_nx;
            boxes_active <= w_en_nx;
        end
    end

    box_border_hit #(
        .IMG_HDISP (IMG_HDISP),
        .IMG_VDISP (IMG_VDISP),
        .HALF_W    (HALF_W),
        .HALF_H    (HALF_H),
        .BORDER    (BORDER_THICKNESS)
    ) u_box1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_frame_start),
        .i_en   (boxes_active[0]),
        .i_cx   (w_act_nx.x1),
        .i_cy   (w_act_nx.y1),
        .i_px   (r_x_cnt),
        .i_py   (r_y_cnt),
        .o_hit  (w_hit1)
    );

    box_border_hit #(
        .IMG_HDISP (IMG_HDISP),
        .IMG_VDISP (IMG_VDISP),
        .HALF_W    (HALF_W),
        .HALF_H    (HALF_H),
        .BORDER    (BORDER_THICKNESS)
    ) u_box2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_frame_start),
        .i_en   (boxes_active[1]),
        .i_cx   (w_act_nx.x2),
        .i_cy   (w_act_nx.y2),
        .i_px   (r_x_cnt),
        .i_py   (r_y_cnt),
        .o_hit  (w_hit2)
    );

endmodule

// File: tb/tb_spot_box_overlay.sv
// Directed bench for spot_box_overlay on a reduced 64x40 raster with 20x20 boxes.
module tb_spot_box_overlay;

    localparam int H = 64;
    localparam int V = 40;
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] GREEN = 24'h00FF00;
    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] BLACK = 24'h000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit;
    logic [10:0] x_max_1, x_max_2;
    logic [15:0] y_max_1, y_max_2;
    logic        coords_valid;
    logic        post_frame_vsync, post_frame_href, post_frame_clken;
    logic [23:0] post_img_rgb;
    logic [1:0]  boxes_active;

    int n_checks = 0;
    int n_fail   = 0;
    int frame_err = 0;
    logic chk_en = 1'b0;
    int cur_x = 0, cur_y = 0;

    // Hand-computed box bounds the current frame is expected to show.
    int e1_en, e1x0, e1x1, e1y0, e1y1;
    int e2_en, e2x0, e2x1, e2y0, e2y1;

    logic [3:0] p_d1, p_d2;
    int px_d1, py_d1, px_d2, py_d2;
    logic [23:0] cap [0:V-1][0:H-1];

    always #5 clk = ~clk;

    spot_box_overlay #(
        .IMG_HDISP        (11'd64),
        .IMG_VDISP        (11'd40),
        .BOX_WIDTH        (10'd20),
        .BOX_HEIGHT       (10'd20),
        .BORDER_THICKNESS (4'd2),
        .MISS_LIMIT       (4'd4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .per_img_Bit      (per_img_Bit),
        .x_max_1          (x_max_1),
        .y_max_1          (y_max_1),
        .x_max_2          (x_max_2),
        .y_max_2          (y_max_2),
        .coords_valid     (coords_valid),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_rgb     (post_img_rgb),
        .boxes_active     (boxes_active)
    );

    function automatic logic pat(input int x, input int y);
        return logic'(((x >> 2) ^ (y >> 1)) & 1);
    endfunction

    function automatic logic [23:0] bg(input int x, input int y);
        return pat(x, y) ? WHITE : BLACK;
    endfunction

    function automatic logic on_border(input int en, input int x0, input int x1,
                                       input int y0, input int y1, input int x, input int y);
        if (en == 0) return 1'b0;
        if (x < x0 || x > x1 || y < y0 || y > y1) return 1'b0;
        return (x - x0 < 2) || (x1 - x < 2) || (y - y0 < 2) || (y1 - y < 2);
    endfunction

    function automatic logic [23:0] exp_rgb(input logic ck, input logic b, input int x, input int y);
        if (!ck) return BLACK;
        if (on_border(e1_en, e1x0, e1x1, e1y0, e1y1, x, y)) return RED;
        if (on_border(e2_en, e2x0, e2x1, e2y0, e2y1, x, y)) return GREEN;
        return b ? WHITE : BLACK;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference 2-cycle delay of the driven stream.
    always @(posedge clk) begin
        p_d1  <= {per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit};
        px_d1 <= cur_x;
        py_d1 <= cur_y;
        p_d2  <= p_d1;
        px_d2 <= px_d1;
        py_d2 <= py_d1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            frame_err <= frame_err
                + int'({post_frame_vsync, post_frame_href, post_frame_clken} !== p_d2[3:1])
                + int'(post_img_rgb !== exp_rgb(p_d2[1], p_d2[0], px_d2, py_d2));
            if (p_d2[1] === 1'b1)
                cap[py_d2][px_d2] <= post_img_rgb;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input int a_en, input int ax0, input int ax1, input int ay0, input int ay1,
                           input int b_en, input int bx0, input int bx1, input int by0, input int by1);
        e1_en = a_en; e1x0 = ax0; e1x1 = ax1; e1y0 = ay0; e1y1 = ay1;
        e2_en = b_en; e2x0 = bx0; e2x1 = bx1; e2y0 = by0; e2y1 = by1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " vsync"}, 32'(post_frame_vsync), 32'd0);
        check_eq({tag, " href"},  32'(post_frame_href),  32'd0);
        check_eq({tag, " clken"}, 32'(post_frame_clken), 32'd0);
        check_eq({tag, " rgb"},   32'(post_img_rgb),     32'd0);
        check_eq({tag, " boxes"}, 32'(boxes_active),     32'd0);
    endtask

    task automatic run_frame(input string name, input logic [1:0] exp_ba,
                             input logic strobe_start, input logic strobe_mid, input logic rst_mid,
                             input logic [10:0] sx1, input logic [15:0] sy1,
                             input logic [10:0] sx2, input logic [15:0] sy2);
        int base;
        chk_en = 1'b1;
        base = frame_err;
        x_max_1 = sx1; y_max_1 = sy1; x_max_2 = sx2; y_max_2 = sy2;
        for (int i = 0; i < 4; i++) begin
            per_frame_vsync = 1'b1;
            coords_valid = (i == 0) && strobe_start;
            tick();
        end
        coords_valid = 1'b0;
        per_frame_vsync = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_eq($sformatf("%s boxes_active", name), 32'(boxes_active), 32'(exp_ba));
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                per_frame_href = 1'b1;
                per_frame_clken = 1'b1;
                per_img_Bit = pat(x, y);
                cur_x = x;
                cur_y = y;
                coords_valid = strobe_mid && (y == V / 2) && (x == 5);
                if (rst_mid && (y == V / 2) && (x == 0)) begin
                    chk_en = 1'b0;
                    rst_n = 1'b0;
                    tick();
                    check_reset_outputs($sformatf("%s midreset", name));
                    rst_n = 1'b1;
                end
                tick();
            end
            per_frame_href = 1'b0;
            per_frame_clken = 1'b0;
            per_img_Bit = 1'b0;
            coords_valid = 1'b0;
            cur_x = 0;
            cur_y = 0;
            tick();
            tick();
        end
        for (int i = 0; i < 6; i++) tick();
        if (!rst_mid)
            check_eq($sformatf("%s pixel/timing errors", name), 32'(frame_err - base), 32'd0);
    endtask

    task automatic spot(input string tag, input int x, input int y, input logic [23:0] exp);
        check_eq($sformatf("%s (%0d,%0d)", tag, x, y), 32'(cap[y][x]), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0;
        per_frame_vsync = 1'b0;
        per_frame_href = 1'b0;
        per_frame_clken = 1'b0;
        per_img_Bit = 1'b0;
        coords_valid = 1'b0;
        x_max_1 = '0; y_max_1 = '0; x_max_2 = '0; y_max_2 = '0;
        set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // F0: no active coordinates; strobe centres for F1
        run_frame("F0", 2'b00, 1'b0, 1'b1, 1'b0, 11'd32, 16'd20, 11'd15, 16'd12);

        set_exp(1, 22, 42, 10, 30, 1, 5, 25, 2, 22);
        run_frame("F1", 2'b11, 1'b0, 1'b1, 1'b0, 11'd32, 16'd20, 11'd32, 16'd20);
        spot("F1 red left",      22, 20, RED);
        spot("F1 red left",      23, 20, RED);
        spot("F1 red right",     41, 20, RED);
        spot("F1 red right",     42, 20, RED);
        spot("F1 red top",       32, 10, RED);
        spot("F1 red bottom",    32, 30, RED);
        spot("F1 inner",         32, 12, bg(32, 12));
        spot("F1 inner",         40, 20, bg(40, 20));
        spot("F1 green corner",   5,  5, GREEN);
        spot("F1 green left",     6, 15, GREEN);
        spot("F1 green inner",    7, 15, bg(7, 15));
        spot("F1 green right",   24, 15, GREEN);
        spot("F1 overlap red",   22, 22, RED);
        spot("F1 outside",        0,  0, bg(0, 0));

        // F2: identical boxes, red must cover every shared border pixel
        set_exp(1, 22, 42, 10, 30, 1, 22, 42, 10, 30);
        run_frame("F2", 2'b11, 1'b0, 1'b1, 1'b0, 11'd5, 16'd38, 11'd15, 16'd100);
        spot("F2 shared top",    32, 10, RED);
        spot("F2 shared right",  42, 20, RED);

        // F3: box1 clamped to x 0..15, y 28..39; box2 off-screen and disabled
        set_exp(1, 0, 15, 28, 39, 0, 0, 0, 0, 0);
        run_frame("F3", 2'b01, 1'b0, 1'b0, 1'b0, 11'd5, 16'd38, 11'd15, 16'd100);
        spot("F3 clamp x0",       0, 33, RED);
        spot("F3 clamp x1",       1, 33, RED);
        spot("F3 clamp inner",    2, 33, bg(2, 33));
        spot("F3 clamp bottom",   8, 39, RED);
        spot("F3 clamp bottom",   8, 38, RED);
        spot("F3 clamp inner",    8, 37, bg(8, 37));
        spot("F3 clamp top",     15, 28, RED);
        spot("F3 above",          8, 27, bg(8, 27));

        // Misses 1..3 keep drawing; the fourth hides the boxes
        run_frame("F4", 2'b01, 1'b0, 1'b0, 1'b0, 11'd5, 16'd38, 11'd15, 16'd100);
        run_frame("F5", 2'b01, 1'b0, 1'b0, 1'b0, 11'd5, 16'd38, 11'd15, 16'd100);
        run_frame("F6", 2'b01, 1'b0, 1'b0, 1'b0, 11'd5, 16'd38, 11'd15, 16'd100);
        set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_frame("F7", 2'b00, 1'b0, 1'b1, 1'b0, 11'd32, 16'd20, 11'd15, 16'd12);
        spot("F7 hidden",         0, 33, bg(0, 33));

        set_exp(1, 22, 42, 10, 30, 1, 5, 25, 2, 22);
        run_frame("F8", 2'b11, 1'b0, 1'b0, 1'b0, 11'd32, 16'd20, 11'd15, 16'd12);
        spot("F8 re-enabled",    22, 22, RED);

        // F9: strobe on the frame-start cycle must not affect this frame
        run_frame("F9", 2'b11, 1'b1, 1'b0, 1'b0, 11'd5, 16'd38, 11'd15, 16'd100);
        spot("F9 old box",       22, 22, RED);
        spot("F9 no new box",     0, 33, bg(0, 33));

        set_exp(1, 0, 15, 28, 39, 0, 0, 0, 0, 0);
        run_frame("F10", 2'b01, 1'b0, 1'b0, 1'b0, 11'd5, 16'd38, 11'd15, 16'd100);
        spot("F10 deferred box",  0, 33, RED);

        run_frame("F11", 2'b01, 1'b0, 1'b0, 1'b1, 11'd5, 16'd38, 11'd15, 16'd100);

        set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_frame("F12", 2'b00, 1'b0, 1'b0, 1'b0, 11'd5, 16'd38, 11'd15, 16'd100);
        spot("F12 after reset",   0, 33, bg(0, 33));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
